// File: rtl/apb_requester_if.sv
// Command, response and APB bus signals of the APB requester, grouped as one bundle.
// The requester uses the master view; the command source / APB completer side uses the slave view.
interface apb_requester_if #(
    parameter int ADDR_WIDTH     = 12,
    parameter int WAIT_CNT_WIDTH = 8
);
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic                      cmd_write;
    logic [ADDR_WIDTH-1:0]     cmd_addr;
    logic [31:0]               cmd_wdata;
    logic [3:0]                cmd_strb;

    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [31:0]               rsp_rdata;
    logic                      rsp_err;
    logic [WAIT_CNT_WIDTH-1:0] rsp_waits;

    logic [ADDR_WIDTH-1:0]     PADDR;
    logic                      PSEL;
    logic                      PENABLE;
    logic                      PWRITE;
    logic [31:0]               PWDATA;
    logic [3:0]                PSTRB;
    logic                      PREADY;
    logic [31:0]               PRDATA;
    logic                      PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_waits,
        input  rsp_ready,
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
        input  PREADY, PRDATA, PSLVERR
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_waits,
        output rsp_ready,
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
        output PREADY, PRDATA, PSLVERR
    );
endinterface

// File: rtl/apb_requester.sv
// APB4 requester: one command in flight, registered APB outputs, and a
// saturating wait-state count returned with every completion.
module apb_requester #(
    parameter int ADDR_WIDTH     = 12,
    parameter int WAIT_CNT_WIDTH = 8
) (
    input  logic            PCLK,
    input  logic            PRESETn,
    apb_requester_if.master bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_MAX = '1;

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [31:0]           wdata;
        logic [3:0]            strb;
    } req_t;

    typedef struct packed {
        logic                      valid;
        logic [31:0]               rdata;
        logic                      err;
        logic [WAIT_CNT_WIDTH-1:0] waits;
    } rsp_t;

    logic [1:0] state;
    req_t       req_q;
    rsp_t       rsp_q;
    logic       psel_q;
    logic       penable_q;

    logic       cmd_fire;
    logic       rsp_fire;

    assign cmd_fire = (state == ST_IDLE) && bus.cmd_valid;
    assign rsp_fire = (state == ST_RESP) && bus.rsp_ready;

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state     <= ST_IDLE;
            req_q     <= '0;
            rsp_q     <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_fire) begin
                        // Reads never drive write data or strobes onto the bus.
                        req_q.write <= bus.cmd_write;
                        req_q.addr  <= {bus.cmd_addr[ADDR_WIDTH-1:2], 2'b00};
                        req_q.wdata <= bus.cmd_write ? bus.cmd_wdata : 32'd0;
                        req_q.strb  <= bus.cmd_write ? bus.cmd_strb  : 4'd0;
                        psel_q      <= 1'b1;
                        state       <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    penable_q   <= 1'b1;
                    rsp_q.waits <= '0;
                    state       <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (bus.PREADY) begin
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_q.valid <= 1'b1;
                        rsp_q.rdata <= req_q.write ? 32'd0 : bus.PRDATA;
                        rsp_q.err   <= bus.PSLVERR;
                        state       <= ST_RESP;
                    end else if (rsp_q.waits != WAIT_MAX) begin
                        rsp_q.waits <= rsp_q.waits + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_fire) begin
                        rsp_q.valid <= 1'b0;
                        rsp_q.waits <= '0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = (state == ST_IDLE);

    assign bus.rsp_valid = rsp_q.valid;
    assign bus.rsp_rdata = rsp_q.rdata;
    assign bus.rsp_err   = rsp_q.err;
    assign bus.rsp_waits = rsp_q.waits;

    assign bus.PSEL    = psel_q;
    assign bus.PENABLE = penable_q;
    assign bus.PADDR   = req_q.addr;
    assign bus.PWRITE  = req_q.write;
    assign bus.PWDATA  = req_q.wdata;
    assign bus.PSTRB   = req_q.strb;

    // APB protocol invariants on the outgoing bus.
    a_enable_needs_sel: assert property (@(posedge PCLK) disable iff (!PRESETn)
        bus.PENABLE |-> bus.PSEL);
    a_setup_before_access: assert property (@(posedge PCLK) disable iff (!PRESETn)
        $rose(bus.PENABLE) |-> $past(bus.PSEL && !bus.PENABLE));
    a_access_stable: assert property (@(posedge PCLK) disable iff (!PRESETn)
        (bus.PSEL && bus.PENABLE) |-> ($stable(bus.PADDR) && $stable(bus.PWRITE) &&
                                       $stable(bus.PWDATA) && $stable(bus.PSTRB)));
endmodule
